// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment constants and the pattern-to-value decoder.
// Segment vectors are active-low, bit 6 = g ... bit 0 = a.
// Optional macro SEG_DECODE_HEX_EN: also accept the A..F glyphs as legal.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0011000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] AN_IDLE   = 4'hF;

    // Returns {legal, value}; unknown patterns come back as {0, 0}.
    function automatic logic [4:0] seg7_to_val(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            SEG_0:   res = {1'b1, 4'h0};
            SEG_1:   res = {1'b1, 4'h1};
            SEG_2:   res = {1'b1, 4'h2};
            SEG_3:   res = {1'b1, 4'h3};
            SEG_4:   res = {1'b1, 4'h4};
            SEG_5:   res = {1'b1, 4'h5};
            SEG_6:   res = {1'b1, 4'h6};
            SEG_7:   res = {1'b1, 4'h7};
            SEG_8:   res = {1'b1, 4'h8};
            SEG_9:   res = {1'b1, 4'h9};
`ifdef SEG_DECODE_HEX_EN
            SEG_A:   res = {1'b1, 4'hA};
            SEG_B:   res = {1'b1, 4'hB};
            SEG_C:   res = {1'b1, 4'hC};
            SEG_D:   res = {1'b1, 4'hD};
            SEG_E:   res = {1'b1, 4'hE};
            SEG_F:   res = {1'b1, 4'hF};
`endif
            default: res = {1'b0, 4'h0};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/seg7_stable_filter.sv
// seg7_stable_filter: 2-flop synchronizer followed by a saturating
// run-length counter; pulses accept once when the synchronized word has
// been held STABLE_CYCLES samples.
module seg7_stable_filter #(
    parameter int               STABLE_CYCLES = 4,
    parameter int               WIDTH         = 11,
    parameter logic [WIDTH-1:0] IDLE          = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             accept
);

    localparam int            CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_SAT = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ACC = CW'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] prev;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic             same;

    // Synchronizer, previous-sample register and run-length counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= IDLE;
            sync2 <= IDLE;
            prev  <= IDLE;
            cnt   <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            prev  <= sync2;
            cnt   <= cnt_next;
        end
    end

    // Next count and single-shot accept when the count first reaches STABLE_CYCLES-1.
    // A mismatch landing on STABLE_CYCLES-1 only happens for STABLE_CYCLES=1,
    // where every change is accepted straight away.
    always_comb begin
        same     = 1'b0;
        cnt_next = '0;
        accept   = 1'b0;
        same = (sync2 == prev);
        if (!same) begin
            cnt_next = '0;
        end else if (cnt == CNT_SAT) begin
            cnt_next = cnt;
        end else begin
            cnt_next = cnt + CW'(1);
        end
        if ((cnt_next == CNT_ACC) && (!same || (cnt != CNT_ACC))) begin
            accept = 1'b1;
        end else begin
            accept = 1'b0;
        end
    end

    assign dout = sync2;

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: passive reader of a multiplexed active-low 7-segment
// bus. Filters scan transitions, decodes stable patterns and keeps the last
// value per digit.
// Optional macro SEG_DECODE_HEX_EN: decode A..F glyphs as legal values.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  an_in,
    output logic [15:0] digits,
    output logic [3:0]  valid,
    output logic [3:0]  err,
    output logic        upd,
    output logic [1:0]  upd_idx
);

    logic [10:0] bus;
    logic        accept;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        one_hot;
    logic [1:0]  idx;
    logic [4:0]  dec;

    seg7_stable_filter #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .WIDTH         (11),
        .IDLE          ({AN_IDLE, SEG_BLANK})
    ) u_filter (
        .clk    (clk),
        .rst    (rst),
        .din    ({an_in, seg_in}),
        .dout   (bus),
        .accept (accept)
    );

    // Split the filtered bus, find the single enabled digit and decode its pattern.
    always_comb begin
        an      = bus[10:7];
        seg     = bus[6:0];
        one_hot = 1'b0;
        idx     = 2'd0;
        case (an)
            4'b1110: begin one_hot = 1'b1; idx = 2'd0; end
            4'b1101: begin one_hot = 1'b1; idx = 2'd1; end
            4'b1011: begin one_hot = 1'b1; idx = 2'd2; end
            4'b0111: begin one_hot = 1'b1; idx = 2'd3; end
            default: begin one_hot = 1'b0; idx = 2'd0; end
        endcase
        dec = seg7_to_val(seg);
    end

    // Capture accepted patterns into the per-digit registers and raise the update strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits  <= 16'h0000;
            valid   <= 4'b0000;
            err     <= 4'b0000;
            upd     <= 1'b0;
            upd_idx <= 2'd0;
        end else begin
            upd <= 1'b0;
            if (accept && one_hot) begin
                upd     <= 1'b1;
                upd_idx <= idx;
                if (dec[4]) begin
                    digits[{idx, 2'b00} +: 4] <= dec[3:0];
                    valid[idx]                <= 1'b1;
                    err[idx]                  <= 1'b0;
                end else begin
                    err[idx] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed, table-driven bench for seg7_scan_decoder
// with STABLE_CYCLES = 4. Honours SEG_DECODE_HEX_EN for hex expectations.
module tb_seg7_scan_decoder;
    import seg7_pkg::*;

`ifdef SEG_DECODE_HEX_EN
    localparam bit HEX = 1'b1;
`else
    localparam bit HEX = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [6:0]  seg_in;
    logic [3:0]  an_in;
    logic [15:0] digits;
    logic [3:0]  valid;
    logic [3:0]  err;
    logic        upd;
    logic [1:0]  upd_idx;

    int n_vec = 0;
    int n_mis = 0;

    seg7_scan_decoder #(.STABLE_CYCLES(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .seg_in  (seg_in),
        .an_in   (an_in),
        .digits  (digits),
        .valid   (valid),
        .err     (err),
        .upd     (upd),
        .upd_idx (upd_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  an;
        logic [6:0]  seg;
        int          cycles;
        logic [15:0] exp_digits;
        logic [3:0]  exp_valid;
        logic [3:0]  exp_err;
        int          exp_upd;
        logic [1:0]  exp_idx;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance n cycles, sampling 1 time unit after each rising edge.
    task automatic run(input int n, output int ups);
        ups = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (upd === 1'b1) ups++;
        end
    endtask

    initial begin
        int ups;
        logic [15:0] d_hex;
        logic [3:0]  e_hex;

        // digit 2 shows 'A' in row 5; its fate depends on the hex option
        d_hex = HEX ? 16'h9A51 : 16'h9351;
        e_hex = HEX ? 4'b0000  : 4'b0100;

        vecs[0]  = '{"scan_d0_1",  4'b1110, SEG_1, 20, 16'h0001, 4'b0001, 4'b0000, 1, 2'd0};
        vecs[1]  = '{"scan_d1_2",  4'b1101, SEG_2, 20, 16'h0021, 4'b0011, 4'b0000, 1, 2'd1};
        vecs[2]  = '{"scan_d2_3",  4'b1011, SEG_3, 20, 16'h0321, 4'b0111, 4'b0000, 1, 2'd2};
        vecs[3]  = '{"scan_d3_9",  4'b0111, SEG_9, 20, 16'h9321, 4'b1111, 4'b0000, 1, 2'd3};
        vecs[4]  = '{"d1_5",       4'b1101, SEG_5, 20, 16'h9351, 4'b1111, 4'b0000, 1, 2'd1};
        vecs[5]  = '{"d2_hexA",    4'b1011, SEG_A, 20, d_hex,    4'b1111, e_hex,   1, 2'd2};
        vecs[6]  = '{"two_low",    4'b1100, SEG_8, 20, d_hex,    4'b1111, e_hex,   0, 2'd2};
        vecs[7]  = '{"none_low",   4'b1111, SEG_8, 20, d_hex,    4'b1111, e_hex,   0, 2'd2};
        vecs[8]  = '{"all_low",    4'b0000, SEG_0, 20, d_hex,    4'b1111, e_hex,   0, 2'd2};
        vecs[9]  = '{"d0_7",       4'b1110, SEG_7, 20, {d_hex[15:4], 4'h7}, 4'b1111, e_hex, 1, 2'd0};
        vecs[10] = '{"d2_4_clr",   4'b1011, SEG_4, 20, {d_hex[15:12], 8'h45, 4'h7}, 4'b1111, 4'b0000, 1, 2'd2};

        // ---- reset and idle bus ----
        rst    = 1'b1;
        an_in  = AN_IDLE;
        seg_in = SEG_BLANK;
        run(3, ups);
        rst = 1'b0;
        run(50, ups);
        check("idle_upd_count", ups, 0);
        check("idle_digits", digits, 16'h0000);
        check("idle_valid", valid, 4'b0000);
        check("idle_err", err, 4'b0000);
        check("idle_upd_idx", upd_idx, 2'd0);

        // ---- latency: pair changes before edge k, upd after edge k+5 ----
        an_in  = 4'b1110;
        seg_in = SEG_2;
        for (int t = 1; t <= 6; t++) begin
            @(posedge clk);
            #1;
            if (t < 6) check($sformatf("lat_no_upd_t%0d", t), upd, 1'b0);
            else       check("lat_upd_t6", upd, 1'b1);
        end
        check("lat_idx", upd_idx, 2'd0);
        check("lat_digits", digits, 16'h0002);
        check("lat_valid", valid, 4'b0001);
        run(100, ups);
        check("hold_no_reaccept", ups, 0);

        // ---- table-driven scan and corner patterns ----
        for (int i = 0; i < 11; i++) begin
            an_in  = vecs[i].an;
            seg_in = vecs[i].seg;
            run(vecs[i].cycles, ups);
            check({vecs[i].name, "_upd"},    ups,     vecs[i].exp_upd);
            check({vecs[i].name, "_digits"}, digits,  vecs[i].exp_digits);
            check({vecs[i].name, "_valid"},  valid,   vecs[i].exp_valid);
            check({vecs[i].name, "_err"},    err,     vecs[i].exp_err);
            check({vecs[i].name, "_idx"},    upd_idx, vecs[i].exp_idx);
        end

        // ---- glitch: digit 1 shows 5, 3-cycle '8' glitch, back to 5 ----
        an_in  = 4'b1101;
        seg_in = SEG_5;
        run(20, ups);
        check("glitch_pre_upd", ups, 1);
        seg_in = SEG_8;
        run(3, ups);
        check("glitch_during_upd", ups, 0);
        seg_in = SEG_5;
        run(20, ups);
        check("glitch_reaccept_upd", ups, 1);
        check("glitch_digit1", digits[7:4], 4'h5);
        check("glitch_idx", upd_idx, 2'd1);

        // ---- reset in the middle of the filter count ----
        an_in  = 4'b1110;
        seg_in = SEG_6;
        run(5, ups);               // counter now at 2 for the new pair
        check("midrst_pre_upd", ups, 0);
        rst = 1'b1;
        #1;
        check("midrst_digits", digits, 16'h0000);
        check("midrst_valid", valid, 4'b0000);
        check("midrst_err", err, 4'b0000);
        check("midrst_upd", upd, 1'b0);
        check("midrst_idx", upd_idx, 2'd0);
        an_in  = AN_IDLE;
        seg_in = SEG_BLANK;
        run(2, ups);
        rst = 1'b0;
        run(20, ups);
        check("postrst_no_upd", ups, 0);
        check("postrst_digits", digits, 16'h0000);
        an_in  = 4'b1110;
        seg_in = SEG_6;
        run(20, ups);
        check("postrst_new_upd", ups, 1);
        check("postrst_new_digits", digits, 16'h0006);
        check("postrst_new_valid", valid, 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Passive reader for a multiplexed, active-low 7-segment display bus (segments g..a, 4 digit enables). It samples the segment and digit-enable lines the counter/display blocks drive, filters scan transitions and ghosting, decodes each stable pattern back to a 4-bit value, and holds the last decoded value per digit. Used for on-board self-check and for feeding display contents back to the bench.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples required before a pattern is accepted; legal range 1..255.
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- seg_in  input  7  segment lines, active-low, bit 6 = g … bit 0 = a.
- an_in  input  4  digit enables, active-low, bit i = digit i.
- digits  output  16  decoded values, digit i in bits [4i+3:4i].
- valid  output  4  bit i set once digit i has held a legal decode.
- err  output  4  bit i set when the last accepted pattern for digit i was illegal.
- upd  output  1  one-cycle strobe per accepted pattern.
- upd_idx  output  2  digit index of the current/last accepted pattern.

## Operation
- Input path: {an_in, seg_in} through a 2-flop synchronizer; reset value 4'hF / 7'h7F (all off).
- Stability filter: counter cnt of width $clog2(STABLE_CYCLES+1), saturating. Each edge: if synchronized pair equals the previous synchronized pair, cnt <= cnt+1 (saturate), else cnt <= 0.
- Accept condition: cnt transitions to STABLE_CYCLES-1 (pair held STABLE_CYCLES samples) AND exactly one an bit low. Fires once per stable interval; no re-accept until the pair changes.
- an with zero or >1 bits low: never accepted, no state change, counter still runs.
- Decode table (seg → value): 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0011000→9.
- Legal accept on digit i: digits[i] <= value, valid[i] <= 1, err[i] <= 0.
- Illegal accept on digit i: err[i] <= 1; digits[i], valid[i] unchanged.
- upd high exactly one cycle per accept (legal or illegal); upd_idx <= i in the same cycle, held afterwards.
- Reset (any time, including mid-filter): digits=0, valid=0, err=0, upd=0, upd_idx=0, cnt=0, sync stages to all-off.

## Timing
- Pair changes before edge k (captured in stage 1 at k): upd high in the cycle following edge k+STABLE_CYCLES+1; digits/valid/err update on that same edge. Latency = STABLE_CYCLES+2 edges.
- STABLE_CYCLES=1: every change to a new one-hot pair accepted after 2 edges.
- Glitch of fewer than STABLE_CYCLES samples: ignored; returning to the prior pair restarts counting and re-accepts it.
- All outputs registered; no combinational input-to-output path.

## Configuration
- SEG_DECODE_HEX_EN defined: additionally legal 0001000→A, 0000011→b, 1000110→C, 0100001→d, 0000110→E, 0001110→F.
- Not defined: those six patterns decode as illegal (err path); table limited to 0–9.

## Structure
- Shared package seg7_pkg: segment pattern constants (SEG_0..SEG_F, SEG_BLANK=7'h7F), digit-count constant (4), decode function seg7_to_val returning {legal, value[3:0]}; the encoder side uses the same constants.
- One sub-module: seg7_stable_filter (synchronizer + stability counter + accept pulse), parameterized by STABLE_CYCLES and data width.

## Test plan
- Reset release, bus idle (an=1111, seg=1111111) for 50 cycles → digits=0, valid=0, err=0, no upd.
- STABLE_CYCLES=4, hold an=1110 seg=0100100 → upd once at latency 6, upd_idx=0, digits[3:0]=2, valid=0001; holding 100 more cycles → no further upd.
- Scan 4 digits (an=1110,1101,1011,0111, 20 cycles each) with 1,2,3,9 → digits=16'h9321, valid=1111, exactly 4 upd pulses.
- Digit 1 shows 5, then 3-cycle glitch seg=0000000, then back to 5 → no accept of 8, digits[7:4]=5, one extra upd for re-accepted 5.
- Pattern 0001000 on digit 2 → with SEG_DECODE_HEX_EN digits[11:8]=A, err[2]=0; without it err[2]=1, digits[11:8] unchanged; an=1100 (two low) → no upd.
- Assert rst during filter count (cnt=2) → all outputs 0 immediately, no upd after release until new stable pair.
